// File: rtl/btn_debounce_sync_pkg.sv
// Shared definitions for the button debouncer: FSM state encodings and
// the qualification counter width helper.
package debounce_defs;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } deb_state_t;

  // Counter only needs to reach n-1; keep at least one bit for n <= 2.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Synchronous active-low reset clears every stage.
module sync_ff_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/btn_debounce_sync.sv
// Button conditioning: synchronise, qualify each level change for
// STABLE_CYCLES clocks, then emit a clean level plus rise/fall strobes.
module btn_debounce_sync
  import debounce_defs::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt, busy_nxt;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
      btn_rise  <= rise_nxt;
      btn_fall  <= fall_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      IDLE_LOW: begin
        if (s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nxt = IDLE_LOW;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE_HIGH;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nxt = IDLE_HIGH;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE_LOW;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
    // Level/busy are decoded from the next state so the registered outputs
    // always agree with the registered state.
    level_nxt = (state_nxt == IDLE_HIGH) || (state_nxt == WAIT_LOW);
    busy_nxt  = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
  end

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Directed bench for btn_debounce_sync: default instance plus a
// STABLE_CYCLES=1 instance driven from the same button and reset.
module tb_btn_debounce_sync;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic lvl0, rise0, fall0, busy0;
  logic lvl1, rise1, fall1, busy1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_debounce_sync #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (lvl0),
    .btn_rise  (rise0),
    .btn_fall  (fall0),
    .busy      (busy0)
  );

  btn_debounce_sync #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (1)
  ) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (lvl1),
    .btn_rise  (rise1),
    .btn_fall  (fall1),
    .busy      (busy1)
  );

  // Output nibble order: {level, rise, fall, busy}
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive btn bit i before edge i, then check nibble i of each expectation.
  task automatic run_seq(input string tag, input int n, input logic [15:0] btn_bits,
                         input logic [63:0] exp0, input logic [63:0] exp1);
    for (int i = 0; i < n; i++) begin
      btn_in = btn_bits[i];
      step();
      chk($sformatf("%s_s4[%0d]", tag, i), {lvl0, rise0, fall0, busy0}, exp0[4*i +: 4]);
      chk($sformatf("%s_s1[%0d]", tag, i), {lvl1, rise1, fall1, busy1}, exp1[4*i +: 4]);
    end
  endtask

  initial begin
    reset  = 1'b0;
    btn_in = 1'b0;
    step();
    step();
    chk("reset_s4", {lvl0, rise0, fall0, busy0}, 4'b0000);
    chk("reset_s1", {lvl1, rise1, fall1, busy1}, 4'b0000);
    reset = 1'b1;

    run_seq("press",   8, 16'h00FF, 64'h8C11_1100, 64'h8888_C100);
    run_seq("release", 8, 16'h0000, 64'h0299_9988, 64'h0000_2988);
    run_seq("glitch",  8, 16'h0001, 64'h0000_0100, 64'h0000_0100);
    run_seq("bounce", 11, 16'h07FB, 64'h8C1_1110_1100, 64'h888_8889_C100);
    run_seq("release2", 8, 16'h0000, 64'h0299_9988, 64'h0000_2988);

    // Abort qualification with the counter at 2.
    run_seq("pre_rst", 5, 16'h001F, 64'h1_1100, 64'h8_C100);
    reset  = 1'b0;
    btn_in = 1'b1;
    step();
    chk("mid_rst_s4", {lvl0, rise0, fall0, busy0}, 4'b0000);
    chk("mid_rst_s1", {lvl1, rise1, fall1, busy1}, 4'b0000);
    reset = 1'b1;
    run_seq("post_rst", 8, 16'h00FF, 64'h8C11_1100, 64'h8888_C100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_debounce_sync.md
Name: btn_debounce_sync

Overview:
- Upstream conditioning stage for the Mealy edge-detector FSM.
- Takes a raw, asynchronous, bouncing push-button/switch input and synchronises it into the clk domain.
- Filters out bounces and glitches, then delivers a clean level (btn_level) that drives the FSM's bi input.
- Also provides registered one-cycle rise/fall strobes and a busy flag for other consumers.

Parameters:
- SYNC_STAGES, 2: flip-flops in the input synchroniser chain; must be >= 2.
- STABLE_CYCLES, 4: consecutive clk cycles the synchronised input must hold a new value before it is accepted; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on clk rising edge).
- btn_in  input  1  raw asynchronous button/switch signal.
- btn_level  output  1  debounced level; connects to the FSM bi input.
- btn_rise  output  1  one-cycle strobe when btn_level goes 0->1.
- btn_fall  output  1  one-cycle strobe when btn_level goes 1->0.
- busy  output  1  high while a candidate transition is being qualified (WAIT_* states).

Behaviour:
- One clock, clk. reset is synchronous and active-low; no asynchronous reset anywhere.
- Reset (reset=0 at a rising edge):
  - synchroniser chain, counter and all outputs cleared to 0;
  - state = IDLE_LOW.
  - Reset mid-qualification aborts it; no strobe is emitted.
- Synchroniser: btn_in is shifted through SYNC_STAGES registers. s = last stage. Only s is used by the FSM.
- All outputs are registered Moore outputs. No combinational path from btn_in to any output.
- Counter: width CNT_W = max(1, clog2(STABLE_CYCLES)). It is cleared to 0 on entry to any WAIT state and never wraps.
- FSM states and transitions:
  - IDLE_LOW (level 0): s=1 -> WAIT_HIGH, cnt=0; else stay.
  - WAIT_HIGH (level 0, busy 1):
    - s=0 -> IDLE_LOW (glitch rejected, no strobe);
    - s=1 and cnt==STABLE_CYCLES-1 -> IDLE_HIGH, btn_level=1, btn_rise=1 for that cycle;
    - otherwise cnt+1.
  - IDLE_HIGH (level 1): s=0 -> WAIT_LOW, cnt=0; else stay.
  - WAIT_LOW (level 1, busy 1):
    - s=1 -> IDLE_HIGH (no strobe);
    - s=0 and cnt==STABLE_CYCLES-1 -> IDLE_LOW, btn_level=0, btn_fall=1 for that cycle;
    - otherwise cnt+1.
- Strobes: btn_rise and btn_fall are high for exactly one cycle and are never both high in the same cycle.
- Latency: if btn_in changes and is first sampled at edge N, btn_level changes after edge N+SYNC_STAGES+STABLE_CYCLES, provided btn_in stays stable throughout. Defaults give 6 edges.
- Bounce: any reversal of s during WAIT returns to the prior IDLE state. Qualification restarts from cnt=0 on the next change.
- Button held high through reset: after release, it is qualified normally and produces one btn_rise. This is intended.
- STABLE_CYCLES=1: the WAIT state lasts one cycle; the transition is accepted if s is still at the new value.

Decomposition:
- Shared header/package debounce_defs:
  - state encodings IDLE_LOW=2'b00, WAIT_HIGH=2'b01, IDLE_HIGH=2'b10, WAIT_LOW=2'b11;
  - the CNT_W computation helper.
- One sub-module: sync_ff_chain.
  - Parameter STAGES.
  - Ports clk, reset, d, q.
  - Same synchronous active-low reset.
  - Reusable for other asynchronous inputs.

Test Plan:
- Clean press: reset 0 for 2 cycles, release, btn_in=1 held -> btn_level=1 and btn_rise=1 exactly 6 edges after the first sampling edge; busy high for 4 cycles before; btn_fall stays 0.
- Glitch: btn_in=1 for 1 cycle, then 0 -> btn_level stays 0, no btn_rise, busy high for exactly 1 cycle.
- Bounce press: btn_in 1,1,0,1 then held 1 -> single btn_rise, 6 edges after the last 0->1 change; no extra strobes.
- Release: from IDLE_HIGH, btn_in=0 held -> btn_level=0 and btn_fall=1 for one cycle, 6 edges after sampling; chained FSM output bo stays 0.
- Reset mid-WAIT_HIGH: assert reset=0 when cnt=2 -> next edge all outputs 0, state IDLE_LOW, no btn_rise; after release with btn_in still 1, a full 6-edge qualification then btn_rise.
- End-to-end with fsm_mealy: press/hold/release sequence -> bo pulses 1 once per accepted press and never on a rejected glitch.
